sa48_job_sequencer: RTL and testbench
=====================================

Name: sa48_job_sequencer

Overview:
- Upstream feeder for the SA48 chunk engine, which processes one 48-bit operand as four 12-bit chunks.
- Accepts 48-bit operands over a valid/ready handshake and buffers one pending job.
- Presents the operand stably to the engine, drives the engine's start handshake (raise, then release), and waits for the engine's result-ready to drop and then return.
- Captures the 48-bit result, returns it downstream over valid/ready, and includes a completion-timeout watchdog.

Parameters:
- START_CYC, 1, number of cycles eng_start is held high per job (≥1).
- TIMEOUT, 64, max cycles spent in RELEASE+WAIT before the job is aborted (≥8).
- CNT_W, 16, width of job_count.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream operand valid
- in_ready  out  1  pending slot free
- in_data  in  48  operand
- op_data  out  48  operand to engine; stable from START until return to IDLE
- eng_start  out  1  engine start (engine startChunks)
- eng_result_ready  in  1  engine result-ready level (high when engine idle)
- eng_result  in  48  engine result word
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  48  captured result
- err_timeout  out  1  one-cycle pulse on job abort
- err_sticky  out  1  set on any abort; cleared only by rst
- job_count  out  CNT_W  completed jobs, wraps modulo 2^CNT_W
- busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0, op_data/out_data 0, pend_valid=0, state IDLE, counters 0. Because in_ready = !pend_valid, in_ready is 1 right after reset.
- Pending register:
  - Accept on in_valid & in_ready.
  - Accepting is allowed in any state, so one job can queue behind the active one.
  - Cleared when IDLE launches the pending job. Launch and new accept in the same cycle are impossible, because in_ready=0 while pending is full.
- IDLE:
  - If pend_valid: op_data <= pend_data, clear pend_valid, start_cnt <= 0, go to START.
  - Otherwise stay.
- START:
  - eng_start=1, start_cnt increments.
  - After START_CYC cycles, go to RELEASE.
- RELEASE:
  - eng_start=0, to_cnt increments (reset to 0 on entry).
  - If eng_result_ready==0, the engine has accepted the job ("armed"); go to WAIT.
  - A high eng_result_ready before arming is ignored.
- WAIT:
  - to_cnt increments.
  - If eng_result_ready==1: out_data <= eng_result, job_count += 1, go to OUT.
- OUT:
  - out_valid=1; out_data held stable.
  - On out_ready, go to IDLE. out_valid drops in the next cycle.
  - No timeout applies in OUT (backpressure is unbounded).
- Timeout:
  - If to_cnt reaches TIMEOUT in RELEASE or WAIT: pulse err_timeout for 1 cycle, set err_sticky, go to IDLE.
  - The aborted job produces no output and does not increment job_count.
  - Completion takes priority over timeout when both occur in the same cycle.
- Reset mid-job: the job and the pending entry are discarded; state returns to IDLE; eng_start deasserts immediately after the reset edge.
- eng_start, out_valid and busy are registered or decoded from state only; there is no combinational path from the inputs to them.
- in_ready is combinational from pend_valid only.
- Nominal latency (START_CYC=1, standard 4-chunk engine): out_valid rises in the cycle after the 8th rising edge following the accepting edge.

Test Plan:
- Single job: in_data=48'h123456789ABC with an engine model echoing ~op_data → eng_start high for exactly 1 cycle; out_valid 8 edges after accept; out_data=48'hEDCBA9876543; job_count=1.
- Back-to-back: 3 jobs offered with in_valid held high → in_ready drops after the 1st accept; 2nd accepted while the 1st is running; outputs arrive in order; job_count=3; no gap beyond one IDLE cycle between jobs.
- Backpressure: out_ready=0 for 20 cycles → out_valid and out_data stable; a queued job does not launch until out_ready=1; no timeout.
- Early ready: engine holds eng_result_ready=1 for 2 cycles after start → still in RELEASE, no capture; capture only after ready low then high.
- Timeout: engine never drops eng_result_ready, TIMEOUT=64 → err_timeout pulse at 64 cycles in RELEASE; err_sticky=1; out_valid never asserts; job_count unchanged; next job runs normally.
- Reset mid-WAIT: rst asserted for 1 cycle → all outputs 0, in_ready=1, pending job discarded, job_count=0.

Source files
------------

// File: rtl/sa48_job_sequencer.sv
// -----------------------------------------------------------------------------
// sa48_job_sequencer
//
// Upstream feeder for the SA48 chunk engine. Buffers one pending 48-bit job,
// presents the operand to the engine, pulses the engine start for START_CYC
// cycles, waits for result-ready to drop (engine armed) and then return
// (result available), captures the result and hands it downstream. A watchdog
// aborts a job that spends TIMEOUT cycles in RELEASE+WAIT.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready upstream operand handshake (in_ready = pending slot free)
//   in_data           48-bit operand
//   op_data           operand to engine, stable from START until back in IDLE
//   eng_start         engine start strobe
//   eng_result_ready  engine result-ready level (high while engine idle)
//   eng_result        engine result word
//   out_valid/out_ready downstream result handshake
//   out_data          captured result, held while out_valid
//   err_timeout       one-cycle pulse when a job is aborted
//   err_sticky        set on any abort, cleared only by rst
//   job_count         completed jobs, wraps modulo 2^CNT_W
//   busy              sequencer not in IDLE
// -----------------------------------------------------------------------------
module sa48_job_sequencer #(
   parameter int START_CYC = 1,
   parameter int TIMEOUT   = 64,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [47:0]      in_data,
   output logic [47:0]      op_data,
   output logic             eng_start,
   input  logic             eng_result_ready,
   input  logic [47:0]      eng_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [47:0]      out_data,
   output logic             err_timeout,
   output logic             err_sticky,
   output logic [CNT_W-1:0] job_count,
   output logic             busy
);

   localparam int START_W = (START_CYC > 1) ? $clog2(START_CYC) : 1;
   localparam int TO_W    = $clog2(TIMEOUT + 1);

   localparam logic [START_W-1:0] START_LAST = START_W'(START_CYC - 1);
   localparam logic [START_W-1:0] START_ONE  = START_W'(1);
   localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0]    TO_ONE     = TO_W'(1);
   localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_RELEASE = 3'd2,
      ST_WAIT    = 3'd3,
      ST_OUT     = 3'd4
   } state_t;

   state_t             state_r;
   state_t             state_next_s;
   logic               pend_valid_r;
   logic [47:0]        pend_data_r;
   logic [47:0]        op_data_r;
   logic [47:0]        out_data_r;
   logic [START_W-1:0] start_cnt_r;
   logic [TO_W-1:0]    to_cnt_r;
   logic [CNT_W-1:0]   job_count_r;
   logic               eng_start_r;
   logic               out_valid_r;
   logic               busy_r;
   logic               err_timeout_r;
   logic               err_sticky_r;
   logic               accept_s;
   logic               launch_s;
   logic               capture_s;
   logic               abort_s;

   // The slot is free exactly when nothing is pending, so launch and a new
   // accept can never coincide.
   assign accept_s = in_valid & ~pend_valid_r;

   // Next-state decode plus the launch/capture/abort strobes.
   always_comb begin
      state_next_s = state_r;
      launch_s     = 1'b0;
      capture_s    = 1'b0;
      abort_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (pend_valid_r) begin
               launch_s     = 1'b1;
               state_next_s = ST_START;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (start_cnt_r == START_LAST) begin
               state_next_s = ST_RELEASE;
            end else begin
               state_next_s = ST_START;
            end
         end
         ST_RELEASE: begin
            // A high ready here is the engine still idle, not a result.
            if (to_cnt_r >= TO_LAST) begin
               abort_s      = 1'b1;
               state_next_s = ST_IDLE;
            end else if (!eng_result_ready) begin
               state_next_s = ST_WAIT;
            end else begin
               state_next_s = ST_RELEASE;
            end
         end
         ST_WAIT: begin
            // Completion wins over an expiring watchdog in the same cycle.
            if (eng_result_ready) begin
               capture_s    = 1'b1;
               state_next_s = ST_OUT;
            end else if (to_cnt_r >= TO_LAST) begin
               abort_s      = 1'b1;
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_WAIT;
            end
         end
         ST_OUT: begin
            if (out_ready) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_OUT;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State register; status outputs registered from the next state so they
   // line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         eng_start_r   <= 1'b0;
         out_valid_r   <= 1'b0;
         busy_r        <= 1'b0;
         err_timeout_r <= 1'b0;
         err_sticky_r  <= 1'b0;
      end else begin
         state_r       <= state_next_s;
         eng_start_r   <= (state_next_s == ST_START);
         out_valid_r   <= (state_next_s == ST_OUT);
         busy_r        <= (state_next_s != ST_IDLE);
         err_timeout_r <= abort_s;
         if (abort_s) begin
            err_sticky_r <= 1'b1;
         end
      end
   end

   // One-entry pending buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_valid_r <= 1'b0;
         pend_data_r  <= 48'h0;
      end else if (accept_s) begin
         pend_valid_r <= 1'b1;
         pend_data_r  <= in_data;
      end else if (launch_s) begin
         pend_valid_r <= 1'b0;
      end
   end

   // Start-hold counter and RELEASE+WAIT watchdog counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         start_cnt_r <= {START_W{1'b0}};
         to_cnt_r    <= {TO_W{1'b0}};
      end else begin
         if (launch_s) begin
            start_cnt_r <= {START_W{1'b0}};
         end else if (state_r == ST_START) begin
            start_cnt_r <= start_cnt_r + START_ONE;
         end
         if (state_r == ST_START) begin
            to_cnt_r <= {TO_W{1'b0}};
         end else if ((state_r == ST_RELEASE) || (state_r == ST_WAIT)) begin
            to_cnt_r <= to_cnt_r + TO_ONE;
         end
      end
   end

   // Operand presentation, result capture and completed-job count.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_data_r   <= 48'h0;
         out_data_r  <= 48'h0;
         job_count_r <= {CNT_W{1'b0}};
      end else begin
         if (launch_s) begin
            op_data_r <= pend_data_r;
         end
         if (capture_s) begin
            out_data_r  <= eng_result;
            job_count_r <= job_count_r + CNT_ONE;
         end
      end
   end

   assign in_ready    = ~pend_valid_r;
   assign op_data     = op_data_r;
   assign eng_start   = eng_start_r;
   assign out_valid   = out_valid_r;
   assign out_data    = out_data_r;
   assign err_timeout = err_timeout_r;
   assign err_sticky  = err_sticky_r;
   assign job_count   = job_count_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_sa48_job_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for sa48_job_sequencer with a behavioural chunk-engine
// model that returns ~op_data. Expected results are queued when a job is
// offered and compared when the sequencer presents its output.
// -----------------------------------------------------------------------------
module tb_sa48_job_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [47:0] in_data = 48'h0;
   logic [47:0] op_data;
   logic        eng_start;
   logic        eng_result_ready;
   logic [47:0] eng_result;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [47:0] out_data;
   logic        err_timeout;
   logic        err_sticky;
   logic [15:0] job_count;
   logic        busy;

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          exp_count = 0;
   int          eng_mode = 0;   // 0 normal, 1 never arms, 2 ready stays high 2 cycles
   int          eng_phase = 0;
   int          eng_cnt = 0;
   logic [47:0] sb_q[$];

   sa48_job_sequencer #(.START_CYC(1), .TIMEOUT(64), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .op_data(op_data), .eng_start(eng_start),
      .eng_result_ready(eng_result_ready), .eng_result(eng_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .err_timeout(err_timeout), .err_sticky(err_sticky),
      .job_count(job_count), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Engine model: load cycle plus four chunk cycles, result = ~operand.
   always @(posedge clk) begin
      if (rst) begin
         eng_result_ready <= 1'b1;
         eng_result       <= 48'h0;
         eng_phase        <= 0;
         eng_cnt          <= 0;
      end else begin
         case (eng_phase)
            0: if (eng_start && eng_mode != 1) begin
                  eng_cnt <= 0;
                  if (eng_mode == 2) eng_phase <= 1;
                  else begin eng_result_ready <= 1'b0; eng_phase <= 2; end
               end
            1: if (eng_cnt == 1) begin
                  eng_result_ready <= 1'b0; eng_cnt <= 0; eng_phase <= 2;
               end else eng_cnt <= eng_cnt + 1;
            2: if (eng_cnt == 4) begin
                  eng_result_ready <= 1'b1; eng_result <= ~op_data; eng_phase <= 0;
               end else eng_cnt <= eng_cnt + 1;
            default: eng_phase <= 0;
         endcase
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench time limit");
   end

   // Offer one operand; called and returns at a negedge, past the accept edge.
   task automatic send(input logic [47:0] d, input bit exp_out, input bit hold,
                       output int acc_cyc);
      int g = 0;
      in_data  = d;
      in_valid = 1'b1;
      while (!in_ready && g < 400) begin @(negedge clk); g++; end
      vectors++;
      if (!in_ready) begin
         miscompares++;
         $display("FAIL send_accept: in_ready got %b expected 1 within 400 cycles", in_ready);
      end
      if (exp_out) sb_q.push_back(~d);
      @(negedge clk);
      acc_cyc = cyc;
      if (!hold) in_valid = 1'b0;
   endtask

   // Wait (bounded) for out_valid, counting start and error strobes on the way.
   task automatic wait_output(output logic [47:0] d, output int seen, output int n_start,
                              output int n_err, output bit ok);
      int g = 0;
      n_start = 0; n_err = 0;
      while (!out_valid && g < 400) begin
         if (eng_start) n_start++;
         if (err_timeout) n_err++;
         @(negedge clk);
         g++;
      end
      ok   = out_valid;
      d    = out_data;
      seen = cyc;
   endtask

   task automatic accept_output(output int hs_cyc);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      hs_cyc = cyc;
   endtask

   task automatic pop_exp(output logic [47:0] e);
      if (sb_q.size() > 0) e = sb_q.pop_front();
      else e = 48'hX;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({in_ready, eng_start, out_valid, busy, err_timeout, err_sticky} !== 6'b100000) begin
         miscompares++;
         $display("FAIL reset_flags: got %b expected 100000",
                  {in_ready, eng_start, out_valid, busy, err_timeout, err_sticky});
      end
      vectors++;
      if ({op_data, out_data, job_count} !== 112'h0) begin
         miscompares++;
         $display("FAIL reset_data: op %h out %h cnt %0d expected all 0", op_data, out_data, job_count);
      end
   endtask

   task automatic test_single();
      logic [47:0] d, e;
      int acc, seen, ns, ne, hs;
      bit ok;
      send(48'h123456789ABC, 1'b1, 1'b0, acc);
      wait_output(d, seen, ns, ne, ok);
      pop_exp(e);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL single_valid: out_valid got 0 expected 1"); end
      vectors++;
      if (seen - acc != 8) begin miscompares++; $display("FAIL single_latency: got %0d edges expected 8", seen - acc); end
      vectors++;
      if (ns != 1) begin miscompares++; $display("FAIL single_start_len: got %0d cycles expected 1", ns); end
      vectors++;
      if (d !== e) begin miscompares++; $display("FAIL single_data: got %h expected %h", d, e); end
      accept_output(hs);
      exp_count++;
      vectors++;
      if (job_count !== 16'(exp_count)) begin miscompares++; $display("FAIL single_count: got %0d expected %0d", job_count, exp_count); end
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_drop: out_valid got %b expected 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [47:0] jobs [3];
      int acc0 = 0;
      jobs[0] = 48'h0000_1111_2222;
      jobs[1] = 48'hA5A5_5A5A_F00F;
      jobs[2] = 48'hFFFF_0000_8001;
      fork
         begin
            int a;
            for (int i = 0; i < 3; i++) begin
               send(jobs[i], 1'b1, (i < 2), a);
               if (i == 0) begin
                  acc0 = a;
                  vectors++;
                  if (in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_in_ready: got %b expected 0", in_ready); end
               end
            end
         end
         begin
            logic [47:0] d, e;
            int seen, ns, ne, hs = 0;
            bit ok;
            for (int k = 0; k < 3; k++) begin
               wait_output(d, seen, ns, ne, ok);
               pop_exp(e);
               vectors++;
               if (!ok || d !== e) begin miscompares++; $display("FAIL b2b_data%0d: got %h valid %b expected %h", k, d, ok, e); end
               vectors++;
               if ((k == 0 ? seen - acc0 : seen - hs) != 8) begin
                  miscompares++;
                  $display("FAIL b2b_gap%0d: got %0d edges expected 8", k, (k == 0 ? seen - acc0 : seen - hs));
               end
               accept_output(hs);
               exp_count++;
            end
         end
      join
      vectors++;
      if (job_count !== 16'(exp_count)) begin miscompares++; $display("FAIL b2b_count: got %0d expected %0d", job_count, exp_count); end
   endtask

   task automatic test_backpressure();
      logic [47:0] d, e, held;
      int acc_a, acc_b, seen, ns, ne, hs;
      bit ok, stable = 1'b1;
      send(48'hDEAD_BEEF_0001, 1'b1, 1'b0, acc_a);
      send(48'h0123_4567_89AB, 1'b1, 1'b0, acc_b);
      wait_output(d, seen, ns, ne, ok);
      held = out_data;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_data !== held || eng_start !== 1'b0 ||
             err_timeout !== 1'b0 || busy !== 1'b1) stable = 1'b0;
      end
      vectors++;
      if (!stable) begin miscompares++; $display("FAIL bp_stable: out held %b expected 1", stable); end
      pop_exp(e);
      vectors++;
      if (!ok || held !== e) begin miscompares++; $display("FAIL bp_data_a: got %h expected %h", held, e); end
      accept_output(hs);
      exp_count++;
      wait_output(d, seen, ns, ne, ok);
      pop_exp(e);
      vectors++;
      if (seen - hs != 8 || ns != 1) begin miscompares++; $display("FAIL bp_launch_b: got %0d edges %0d starts expected 8 and 1", seen - hs, ns); end
      vectors++;
      if (!ok || d !== e) begin miscompares++; $display("FAIL bp_data_b: got %h expected %h", d, e); end
      accept_output(hs);
      exp_count++;
      vectors++;
      if (job_count !== 16'(exp_count) || err_sticky !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_count: got %0d sticky %b expected %0d sticky 0", job_count, err_sticky, exp_count);
      end
   endtask

   task automatic test_early_ready();
      logic [47:0] d, e;
      int acc, seen, ns, ne, hs;
      bit ok;
      eng_mode = 2;
      send(48'h5555_AAAA_3C3C, 1'b1, 1'b0, acc);
      wait_output(d, seen, ns, ne, ok);
      pop_exp(e);
      vectors++;
      if (!ok || seen - acc != 10) begin miscompares++; $display("FAIL early_latency: got %0d edges expected 10", seen - acc); end
      vectors++;
      if (d !== e) begin miscompares++; $display("FAIL early_data: got %h expected %h", d, e); end
      accept_output(hs);
      exp_count++;
      eng_mode = 0;
      vectors++;
      if (job_count !== 16'(exp_count)) begin miscompares++; $display("FAIL early_count: got %0d expected %0d", job_count, exp_count); end
   endtask

   task automatic test_timeout();
      logic [47:0] d, e;
      int acc, seen, ns, ne, hs, rel = 0, g = 0;
      bit ok, ov = 1'b0;
      eng_mode = 1;
      send(48'h0F0F_0F0F_0F0F, 1'b0, 1'b0, acc);
      while (!err_timeout && g < 300) begin
         if (busy && !eng_start) rel++;
         if (out_valid) ov = 1'b1;
         @(negedge clk);
         g++;
      end
      vectors++;
      if (!err_timeout || rel != 64) begin miscompares++; $display("FAIL to_cycles: got %0d release cycles pulse %b expected 64", rel, err_timeout); end
      vectors++;
      if (ov || job_count !== 16'(exp_count) || err_sticky !== 1'b1) begin
         miscompares++;
         $display("FAIL to_effects: out_valid %b count %0d sticky %b expected 0 %0d 1", ov, job_count, err_sticky, exp_count);
      end
      @(negedge clk);
      vectors++;
      if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL to_pulse: got %b expected 0", err_timeout); end
      eng_mode = 0;
      send(48'h8000_0000_0007, 1'b1, 1'b0, acc);
      wait_output(d, seen, ns, ne, ok);
      pop_exp(e);
      vectors++;
      if (!ok || seen - acc != 8 || d !== e) begin miscompares++; $display("FAIL to_next_job: got %h after %0d edges expected %h after 8", d, seen - acc, e); end
      accept_output(hs);
      exp_count++;
      vectors++;
      if (job_count !== 16'(exp_count) || err_sticky !== 1'b1) begin
         miscompares++;
         $display("FAIL to_next_count: got %0d sticky %b expected %0d sticky 1", job_count, err_sticky, exp_count);
      end
   endtask

   task automatic test_reset_mid_wait();
      int a1, a2;
      bit quiet = 1'b1;
      send(48'h1111_2222_3333, 1'b0, 1'b0, a1);
      send(48'h4444_5555_6666, 1'b0, 1'b0, a2);
      @(negedge clk);
      vectors++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_pre: busy %b in_ready %b expected 1 0", busy, in_ready); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_count = 0;
      vectors++;
      if ({in_ready, eng_start, out_valid, busy, err_timeout, err_sticky} !== 6'b100000) begin
         miscompares++;
         $display("FAIL rst_mid_flags: got %b expected 100000",
                  {in_ready, eng_start, out_valid, busy, err_timeout, err_sticky});
      end
      vectors++;
      if ({op_data, out_data, job_count} !== 112'h0) begin
         miscompares++;
         $display("FAIL rst_mid_data: op %h out %h cnt %0d expected all 0", op_data, out_data, job_count);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy || out_valid || eng_start) quiet = 1'b0;
      end
      vectors++;
      if (!quiet) begin miscompares++; $display("FAIL rst_discard: pending job launched, quiet %b expected 1", quiet); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_early_ready();
      test_timeout();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
